// File: rtl/decoder_sel_sequencer.sv
// Select/dwell sequencer feeding a 3-to-8 one-hot decoder through a small request FIFO.
// Define DECODER_SEQ_GAP_EN to insert a one-cycle break-before-make gap between selections.
module decoder_sel_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_sel,
    input  logic [DWELL_W-1:0]      req_dwell,
    output logic                    A0,
    output logic                    A1,
    output logic                    A2,
    output logic                    EN,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]      LVL_ZERO = LW'(0);
    localparam logic [LW-1:0]      LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]      LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [DWELL_W-1:0] DW_ZERO  = DWELL_W'(0);
    localparam logic [DWELL_W-1:0] DW_ONE   = DWELL_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef DECODER_SEQ_GAP_EN
    localparam logic [1:0] ST_GAP    = 2'd2;
`endif

    logic [2:0]         r_sel_mem   [DEPTH];
    logic [DWELL_W-1:0] r_dwell_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic               r_ready;
    logic [1:0]         r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [2:0]         r_sel;
    logic               r_en;
    logic               r_done;
    logic               r_busy;

    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [DWELL_W-1:0] w_head_dwell;
    logic [DWELL_W-1:0] w_load_cnt;
    logic [LW-1:0]      w_level_nxt;
    logic [1:0]         w_state_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;

    // req_ready is a register, so a same-cycle pop never opens a full FIFO
    assign w_push       = req_valid && r_ready;
    assign w_nonempty   = (r_level != LVL_ZERO);
    assign w_head_dwell = r_dwell_mem[r_rd_ptr];

    // Dwell of zero runs as a single cycle; counter holds remaining cycles after this one
    always_comb begin
        w_load_cnt = DW_ZERO;
        if (w_head_dwell == DW_ZERO) begin
            w_load_cnt = DW_ZERO;
        end else begin
            w_load_cnt = w_head_dwell - DW_ONE;
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Sequencer next-state, dwell countdown and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = w_load_cnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (r_cnt != DW_ZERO) begin
                    w_cnt_nxt = r_cnt - DW_ONE;
`ifdef DECODER_SEQ_GAP_EN
                end else begin
                    w_state_nxt = ST_GAP;
                end
`else
                end else if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = w_load_cnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
`ifdef DECODER_SEQ_GAP_EN
            ST_GAP: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = w_load_cnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because pointers and level are cleared
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sel_mem[r_wr_ptr]   <= req_sel;
            r_dwell_mem[r_wr_ptr] <= req_dwell;
        end
    end

    // Control state and registered decoder outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= LVL_ZERO;
            r_ready  <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= DW_ZERO;
            r_sel    <= 3'b000;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != LVL_FULL);
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt == ST_ACTIVE);
            r_done  <= (w_state_nxt == ST_ACTIVE) && (w_cnt_nxt == DW_ZERO);
            r_busy  <= (w_state_nxt != ST_IDLE) || (w_level_nxt != LVL_ZERO);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_sel    <= r_sel_mem[r_rd_ptr];
            end
        end
    end

    assign req_ready = r_ready;
    assign A0        = r_sel[0];
    assign A1        = r_sel[1];
    assign A2        = r_sel[2];
    assign EN        = r_en;
    assign done      = r_done;
    assign busy      = r_busy;
    assign level     = r_level;

endmodule

// File: doc/decoder_sel_sequencer.md
# decoder_sel_sequencer

Upstream sequencer for the 3-to-8 one-hot decoder stage. Accepts select requests (3-bit index plus dwell time) over a valid/ready handshake, buffers them in a small FIFO, and drives the decoder's A2..A0/EN inputs so each selected line is enabled for exactly its dwell time. A break-before-make gap between consecutive selections is optional.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- DWELL_W, 8, width of the dwell field in cycles.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on clk rising edge.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; equals !full.
- req_sel  input  3  line index to enable.
- req_dwell  input  DWELL_W  EN-high duration in cycles; 0 is treated as 1.
- A0, A1, A2  output  1 each  registered select to the decoder; {A2,A1,A0} = sel.
- EN  output  1  registered decoder enable.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- done  output  1  one-cycle pulse in the last EN-high cycle of each entry.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Accept on req_valid && req_ready. Each accepted entry is written into the FIFO at that edge.
- req_ready depends only on registered occupancy. There is no combinational path from the pop to req_ready. When the FIFO is full and pops in the same cycle, the request is still refused that cycle.
- Push and pop in the same cycle: occupancy is unchanged and both operations take effect.
- FSM states: IDLE, ACTIVE, GAP.
  - IDLE: EN=0. If the FIFO is non-empty, pop, load sel onto A2..A0, load cnt = max(dwell,1)-1, and go to ACTIVE.
  - ACTIVE: EN=1. While cnt != 0, decrement cnt. When cnt == 0, assert done, then:
    - if DECODER_SEQ_GAP_EN is defined, go to GAP;
    - otherwise, if the FIFO is non-empty, pop and reload (stay in ACTIVE); if it is empty, go to IDLE.
  - GAP (macro only): EN=0 for exactly one cycle, then behaves as IDLE. If the FIFO is non-empty, pop and go to ACTIVE; otherwise go to IDLE.
- A2..A0 change only on a pop. They hold the last value while EN=0.
- Dwell arithmetic is unsigned DWELL_W-bit. The maximum dwell is 2^DWELL_W-1 cycles, with no overflow.
- FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by level.
- Reset (rst_n=0 at an edge):
  - FIFO is flushed, state goes to IDLE, and any in-progress dwell is abandoned.
  - Outputs after reset: EN=0, A2..A0=000, done=0, busy=0, level=0, req_ready=1.
  - A request presented while rst_n=0 is not accepted.

## Timing
- Latency from accept edge (cycle N) into an empty, IDLE block: FIFO non-empty in N+1, pop at the end of N+1, EN=1 and A valid from N+2.
- EN stays high exactly max(dwell,1) consecutive cycles. done coincides with the final high cycle.
- Back-to-back entries with the macro defined: EN low for exactly 1 cycle between entries, and A changes on the same edge EN rises.
- Back-to-back entries without the macro: EN stays continuously high and A changes on the edge after the done cycle.
- No output is combinational from any input.

## Configuration
- DECODER_SEQ_GAP_EN defined: break-before-make. GAP state is present, giving one EN-low cycle between consecutive selections.
- DECODER_SEQ_GAP_EN undefined: GAP state is removed and consecutive entries run seamlessly, with EN held high.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> level=0, EN=0, {A2,A1,A0}=000, req_ready=1, and no entry is accepted.
- Single request sel=5, dwell=3, accepted at cycle N -> EN=1, A=101 in cycles N+2..N+4; done=1 only at N+4; EN=0 at N+5; busy falls after N+4.
- dwell=0 with sel=2 -> EN high for exactly 1 cycle, done coincides with it, A=010.
- Fill: push 6 requests continuously with DEPTH=4 and dwell=4 -> req_ready drops when level=4, refused requests are not lost by the source, all accepted entries emerge in order, and level never exceeds 4.
- Back-to-back sel=1 (dwell 2) then sel=7 (dwell 1):
  - with DECODER_SEQ_GAP_EN: pattern EN 1,1,0,1, A=001 then 111;
  - without the macro: EN 1,1,1, A changes to 111 in the third cycle.
- Reset mid-dwell: sel=3, dwell=10, rst_n low at the 4th EN-high cycle -> EN=0 and level=0 after that edge, with no done pulse.
